keypad_scanner: RTL and testbench
=================================

# keypad_scanner

- Drives the 4 row lines of the 3x4 matrix keypad and samples its 3 column lines.
- Debounces the scanned key and rejects multi-key presses.
- Outputs a decoded key code with a single-cycle valid strobe.
- Outputs a held, one-hot row/column pair in the format the vending machine controller consumes, so it is the producer side of that keypad interface.

## Interface

Parameters:
- SCAN_DIV, 1000, clock cycles each row is driven (settle time plus sample); must be ≥ 2
- DEBOUNCE_SCANS, 8, consecutive identical full scans required to accept a press or a release; range 1–15

Ports:
- clock_in  input  1  single system clock; all logic on rising edge
- reset_in  input  1  synchronous, active-high reset
- coluna_in  input  3  column sense lines, active high; bit2 = left, bit1 = middle, bit0 = right
- linha_out  output  4  one-hot row drive; 1000 = top row (1,2,3), 0100 = (4,5,6), 0010 = (7,8,9), 0001 = bottom row (*,0,#)
- key_code_out  output  4  decoded key: 0–9 = digits, 10 = `*`, 11 = `#`; holds the last accepted key
- key_valid_out  output  1  one-cycle pulse when a press is accepted
- key_held_out  output  1  high from acceptance until the release is accepted
- coluna_held_out  output  3  one-hot column of the held key; 000 when not held
- linha_held_out  output  4  one-hot row of the held key; 0000 when not held

## Operation

- **Scan engine**
  - Divider counts 0..SCAN_DIV-1 per row.
  - Row index goes 0..3, driving linha_out = 1000, 0100, 0010, 0001 in turn; wraps 3→0.
  - coluna_in is sampled only on the cycle where the divider equals SCAN_DIV-1.
  - The scan engine runs continuously and is never stalled by the debounce FSM.
- **Scan result**, evaluated at the end of row 3, from the 4 samples:
  - NONE: all samples 000.
  - SINGLE: exactly one row has exactly one column bit set.
  - MULTI: anything else. MULTI is treated as NONE for debouncing and never produces a key.
- **Decode for SINGLE**
  - Column 100→1, 010→2, 001→3.
  - Row offset: 1000 +0, 0100 +3, 0010 +6.
  - Bottom row: 100→10 (`*`), 010→0, 001→11 (`#`).
- **Debounce FSM**, 4-bit match counter, updated once per completed scan:
  - IDLE: on a SINGLE result, latch it as candidate, count=1, go to DEBOUNCE; if DEBOUNCE_SCANS=1, accept immediately.
  - DEBOUNCE: same candidate → count+1; a different SINGLE → new candidate, count=1; NONE/MULTI → IDLE. When count reaches DEBOUNCE_SCANS: accept, go to HELD.
  - Accept: load key_code_out and the held row/column, pulse key_valid_out, set key_held_out.
  - HELD: the candidate is still seen → count=0; anything else → count+1. When count reaches DEBOUNCE_SCANS → release: clear key_held_out and the held pair, go to IDLE. A different key while HELD counts toward release only; no second strobe is issued.
- Autorepeat is not supported; one strobe per physical press.

## Timing

- **Reset** (synchronous, dominates everything):
  - divider=0, row=0, linha_out=1000.
  - key_code_out=0, key_valid_out=0, key_held_out=0.
  - coluna_held_out=000, linha_held_out=0000.
  - FSM=IDLE, counters=0, candidate cleared.
- Reset mid-press aborts any debounce or hold with no strobe. Scanning restarts at row 0 on the cycle after reset deasserts.
- Scan period is 4·SCAN_DIV cycles. A scan completes on the cycle row 3's sample is taken.
- FSM updates, key_valid_out, key_held_out, key_code_out and the held pair all change on the cycle after scan completion (registered outputs).
- Minimum latency from a key stable before row 0 of scan k to the strobe is the end of scan k+DEBOUNCE_SCANS-1, plus 1 cycle.
- key_valid_out is never high for two consecutive cycles. Consecutive strobes are separated by at least 2·DEBOUNCE_SCANS scans.
- key_code_out is stable while key_held_out=1 and retains its value after release.

## Test plan

Bench parameters: SCAN_DIV=4, DEBOUNCE_SCANS=3, so the scan period is 16 cycles.

1. Reset, no keys → linha_out cycles 1000/0100/0010/0001 with each row held 4 cycles; all key outputs stay 0.
2. Press "5" (coluna_in=010 whenever linha_out=0100) from cycle 0 → single key_valid_out pulse at cycle 48 with key_code_out=5, coluna_held_out=010, linha_held_out=0100; the pair clears 3 scans after release.
3. Press "*" (100 on row 0001), then "#" (001 on row 0001) → codes 10 then 11; press "0" → code 0.
4. Bounce: "8" present for 2 scans, absent for 1, present for 3 → exactly one strobe, code 8, at the end of the last 3-scan run.
5. Press "1" and "9" together → no strobe, key_held_out stays 0.
6. Assert reset_in for 1 cycle while "4" is in DEBOUNCE (after 2 scans) → no strobe. After reset, 3 fresh scans → strobe with code 4.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Keypad-to-controller link: decoded key, strobe, and the held one-hot row/column pair.
// The scanner drives it through the master modport; the vending controller listens as slave.
interface keypad_scanner_if;
  logic [3:0] key_code_out;
  logic       key_valid_out;
  logic       key_held_out;
  logic [2:0] coluna_held_out;
  logic [3:0] linha_held_out;

  modport master (
    output key_code_out,
    output key_valid_out,
    output key_held_out,
    output coluna_held_out,
    output linha_held_out
  );

  modport slave (
    input key_code_out,
    input key_valid_out,
    input key_held_out,
    input coluna_held_out,
    input linha_held_out
  );
endinterface

// File: rtl/keypad_scanner.sv
// 3x4 matrix keypad scanner: row drive, column sampling, debounce with multi-key rejection,
// and a registered key code, single-cycle strobe and held row/column pair.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 8
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic [2:0]       coluna_in,
  output logic [3:0]       linha_out,
  keypad_scanner_if.master kp
);

  localparam int unsigned   DivW     = $clog2(SCAN_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [3:0]    DbTarget = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {StIdle, StDebounce, StHeld} state_e;

  // Scan engine
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      row_q, row_d;
  logic [2:0]      samp0_q, samp1_q, samp2_q;
  logic            sample_en, scan_done;

  always_comb begin
    sample_en = (div_q == DivLast);
    scan_done = sample_en && (row_q == 2'd3);
    div_d     = sample_en ? '0 : div_q + DivW'(1);
    row_d     = sample_en ? row_q + 2'd1 : row_q;
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      div_q   <= '0;
      row_q   <= 2'd0;
      samp0_q <= 3'b000;
      samp1_q <= 3'b000;
      samp2_q <= 3'b000;
    end else begin
      div_q <= div_d;
      row_q <= row_d;
      if (sample_en) begin
        case (row_q)
          2'd0:    samp0_q <= coluna_in;
          2'd1:    samp1_q <= coluna_in;
          2'd2:    samp2_q <= coluna_in;
          default: ;
        endcase
      end
    end
  end

  assign linha_out = 4'b1000 >> row_q;

  // Scan classification; row 3 is taken live on the completing cycle
  logic [11:0] scan_bits;
  logic [3:0]  scan_row;
  logic [2:0]  scan_col;
  logic        scan_single;
  logic [3:0]  scan_code;
  logic [3:0]  col_off;

  always_comb begin
    scan_bits   = {samp0_q, samp1_q, samp2_q, coluna_in};
    scan_single = ($countones(scan_bits) == 1);
    scan_row    = {|samp0_q, |samp1_q, |samp2_q, |coluna_in};
    scan_col    = samp0_q | samp1_q | samp2_q | coluna_in;
    col_off     = 4'd0;
    unique case (scan_col)
      3'b100:  col_off = 4'd0;
      3'b010:  col_off = 4'd1;
      3'b001:  col_off = 4'd2;
      default: col_off = 4'd0;
    endcase
    scan_code = 4'd0;
    unique case (scan_row)
      4'b1000: scan_code = 4'd1 + col_off;
      4'b0100: scan_code = 4'd4 + col_off;
      4'b0010: scan_code = 4'd7 + col_off;
      default: scan_code = (col_off == 4'd0) ? 4'd10 : (col_off == 4'd1) ? 4'd0 : 4'd11;
    endcase
  end

  // Debounce FSM and registered outputs
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cand_row_q, cand_row_d;
  logic [2:0] cand_col_q, cand_col_d;
  logic [3:0] cand_code_q, cand_code_d;
  logic [3:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       held_q, held_d;
  logic [2:0] col_held_q, col_held_d;
  logic [3:0] row_held_q, row_held_d;
  logic       same, accept;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_row_d  = cand_row_q;
    cand_col_d  = cand_col_q;
    cand_code_d = cand_code_q;
    code_d      = code_q;
    valid_d     = 1'b0;
    held_d      = held_q;
    col_held_d  = col_held_q;
    row_held_d  = row_held_q;
    accept      = 1'b0;
    same        = scan_single && (scan_row == cand_row_q) && (scan_col == cand_col_q);

    if (scan_done) begin
      unique case (state_q)
        StIdle: begin
          if (scan_single) begin
            cand_row_d  = scan_row;
            cand_col_d  = scan_col;
            cand_code_d = scan_code;
            cnt_d       = 4'd1;
            state_d     = StDebounce;
            accept      = (DbTarget == 4'd1);
          end
        end
        StDebounce: begin
          if (same) begin
            cnt_d  = cnt_q + 4'd1;
            accept = (cnt_q + 4'd1 == DbTarget);
          end else if (scan_single) begin
            cand_row_d  = scan_row;
            cand_col_d  = scan_col;
            cand_code_d = scan_code;
            cnt_d       = 4'd1;
          end else begin
            cnt_d   = 4'd0;
            state_d = StIdle;
          end
        end
        StHeld: begin
          if (same) begin
            cnt_d = 4'd0;
          end else if (cnt_q + 4'd1 == DbTarget) begin
            cnt_d      = 4'd0;
            state_d    = StIdle;
            held_d     = 1'b0;
            col_held_d = 3'b000;
            row_held_d = 4'b0000;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (accept) begin
      state_d    = StHeld;
      cnt_d      = 4'd0;
      valid_d    = 1'b1;
      held_d     = 1'b1;
      code_d     = cand_code_d;
      col_held_d = cand_col_d;
      row_held_d = cand_row_d;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      cand_row_q  <= 4'd0;
      cand_col_q  <= 3'd0;
      cand_code_q <= 4'd0;
      code_q      <= 4'd0;
      valid_q     <= 1'b0;
      held_q      <= 1'b0;
      col_held_q  <= 3'b000;
      row_held_q  <= 4'b0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_row_q  <= cand_row_d;
      cand_col_q  <= cand_col_d;
      cand_code_q <= cand_code_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      held_q      <= held_d;
      col_held_q  <= col_held_d;
      row_held_q  <= row_held_d;
    end
  end

  assign kp.key_code_out    = code_q;
  assign kp.key_valid_out   = valid_q;
  assign kp.key_held_out    = held_q;
  assign kp.coluna_held_out = col_held_q;
  assign kp.linha_held_out  = row_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives the columns, and a scan-level
// behavioural model predicts every output each cycle, plus hand-computed literal checks.
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DB = 3;
  localparam int SP = 4 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] col;
  logic [3:0] lin;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .SCAN_DIV      (SD),
    .DEBOUNCE_SCANS(DB)
  ) dut (
    .clock_in (clk),
    .reset_in (rst),
    .coluna_in(col),
    .linha_out(lin),
    .kp       (kif.master)
  );

  always #5 clk = ~clk;

  // Pressed keys by position p = row*3 + col (row 0 = top, col 0 = left)
  logic [11:0] pressed = '0;

  always_comb begin
    col = 3'b000;
    for (int r = 0; r < 4; r++) begin
      if (lin[3-r]) col = col | {pressed[r*3], pressed[r*3+1], pressed[r*3+2]};
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model
  int          t = 0;
  int          st = 0;
  int          cand = 0;
  int          cnt = 0;
  int          nbits, pos, r;
  logic [11:0] seen = '0;
  logic        live = 1'b0;
  logic [3:0]  e_lin = 4'b1000, e_code = '0, e_linh = '0;
  logic [2:0]  e_colh = '0;
  logic        e_valid = 1'b0, e_held = 1'b0;

  function automatic logic [3:0] code_of(input int p);
    if (p < 9) return 4'(p + 1);
    if (p == 9) return 4'd10;
    if (p == 10) return 4'd0;
    return 4'd11;
  endfunction

  task automatic model_accept();
    e_valid = 1'b1;
    e_held  = 1'b1;
    e_code  = code_of(cand);
    e_colh  = 3'b100 >> (cand % 3);
    e_linh  = 4'b1000 >> (cand / 3);
    st      = 2;
    cnt     = 0;
  endtask

  task automatic model_scan();
    nbits = 0;
    pos   = 0;
    for (int i = 0; i < 12; i++) if (seen[i]) begin nbits++; pos = i; end
    if (st == 0) begin
      if (nbits == 1) begin
        cand = pos; cnt = 1; st = 1;
        if (DB == 1) model_accept();
      end
    end else if (st == 1) begin
      if (nbits == 1 && pos == cand) begin
        cnt++;
        if (cnt == DB) model_accept();
      end else if (nbits == 1) begin
        cand = pos; cnt = 1;
      end else begin
        st = 0; cnt = 0;
      end
    end else begin
      if (nbits == 1 && pos == cand) cnt = 0;
      else cnt++;
      if (cnt == DB) begin
        st = 0; cnt = 0; e_held = 1'b0; e_colh = '0; e_linh = '0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    e_valid = 1'b0;
    if (rst) begin
      t = 0; seen = '0; st = 0; cand = 0; cnt = 0;
      e_code = '0; e_held = 1'b0; e_colh = '0; e_linh = '0;
      live = 1'b1;
    end else begin
      if (t % SD == SD - 1) begin
        r = (t / SD) % 4;
        for (int c = 0; c < 3; c++) if (pressed[r*3+c]) seen[r*3+c] = 1'b1;
        if (r == 3) begin
          model_scan();
          seen = '0;
        end
      end
      t++;
    end
    e_lin = 4'b1000 >> ((t / SD) % 4);
  end

  // Per-cycle comparison against the model
  int         strobes = 0;
  logic [3:0] last_code = '0;

  initial forever begin
    @(negedge clk);
    if (live) begin
      check("linha_out", 32'(lin), 32'(e_lin));
      check("key_code_out", 32'(kif.key_code_out), 32'(e_code));
      check("key_valid_out", 32'(kif.key_valid_out), 32'(e_valid));
      check("key_held_out", 32'(kif.key_held_out), 32'(e_held));
      check("coluna_held_out", 32'(kif.coluna_held_out), 32'(e_colh));
      check("linha_held_out", 32'(kif.linha_held_out), 32'(e_linh));
      if (kif.key_valid_out === 1'b1) begin
        strobes++;
        last_code = kif.key_code_out;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic wait_scan_start();
    int k = 0;
    while (t % SP != 0 && k < 2 * SP) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2 * SP) check("scan_align_timeout", 32'(k), 32'(0));
  endtask

  task automatic press(input int p, input int on_scans, input int off_scans);
    wait_scan_start();
    pressed = 12'(1) << p;
    cycles(on_scans * SP);
    pressed = '0;
    cycles(off_scans * SP);
  endtask

  int s0;
  int kind, scans;
  logic [11:0] mask;

  initial begin
    // 1: reset, no keys
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("t1_linha_row0", 32'(lin), 32'(4'b1000));
    check("t1_code", 32'(kif.key_code_out), 32'(0));
    check("t1_held", 32'(kif.key_held_out), 32'(0));
    cycles(4);
    check("t1_linha_row1", 32'(lin), 32'(4'b0100));
    cycles(8);
    check("t1_linha_row3", 32'(lin), 32'(4'b0001));
    cycles(60);
    check("t1_no_strobe", 32'(strobes), 32'(0));

    // 2: press 5 from cycle 0, strobe at cycle 48
    pressed = 12'(1) << 4;
    do_reset();
    s0 = strobes;
    cycles(47);
    check("t2_valid_c47", 32'(kif.key_valid_out), 32'(0));
    cycles(1);
    check("t2_valid_c48", 32'(kif.key_valid_out), 32'(1));
    check("t2_code", 32'(kif.key_code_out), 32'(5));
    check("t2_col_held", 32'(kif.coluna_held_out), 32'(3'b010));
    check("t2_lin_held", 32'(kif.linha_held_out), 32'(4'b0100));
    check("t2_model_valid", 32'(e_valid), 32'(1));
    check("t2_model_code", 32'(e_code), 32'(5));
    cycles(1);
    check("t2_valid_c49", 32'(kif.key_valid_out), 32'(0));
    wait_scan_start();
    pressed = '0;
    cycles(3 * SP - 1);
    check("t2_held_before_release", 32'(kif.key_held_out), 32'(1));
    cycles(1);
    check("t2_held_released", 32'(kif.key_held_out), 32'(0));
    check("t2_lin_held_clear", 32'(kif.linha_held_out), 32'(0));
    check("t2_code_retained", 32'(kif.key_code_out), 32'(5));
    check("t2_one_strobe", 32'(strobes - s0), 32'(1));

    // 3: *, #, 0
    s0 = strobes;
    press(9, 5, 5);
    check("t3_star", 32'(last_code), 32'(10));
    press(11, 5, 5);
    check("t3_hash", 32'(last_code), 32'(11));
    press(10, 5, 5);
    check("t3_zero", 32'(last_code), 32'(0));
    check("t3_strobes", 32'(strobes - s0), 32'(3));

    // 4: bounce on 8
    wait_scan_start();
    s0 = strobes;
    pressed = 12'(1) << 7;
    cycles(2 * SP);
    pressed = '0;
    cycles(SP);
    pressed = 12'(1) << 7;
    cycles(3 * SP);
    check("t4_valid_end_run", 32'(kif.key_valid_out), 32'(1));
    check("t4_code", 32'(kif.key_code_out), 32'(8));
    cycles(SP);
    pressed = '0;
    cycles(4 * SP);
    check("t4_strobes", 32'(strobes - s0), 32'(1));

    // 5: 1 and 9 together
    wait_scan_start();
    s0 = strobes;
    pressed = (12'(1) << 0) | (12'(1) << 8);
    cycles(6 * SP);
    check("t5_held", 32'(kif.key_held_out), 32'(0));
    check("t5_strobes", 32'(strobes - s0), 32'(0));
    pressed = '0;

    // 6: reset aborts debounce of 4
    do_reset();
    pressed = 12'(1) << 3;
    s0 = strobes;
    cycles(2 * SP);
    do_reset();
    check("t6_no_strobe", 32'(strobes - s0), 32'(0));
    check("t6_held", 32'(kif.key_held_out), 32'(0));
    cycles(3 * SP);
    check("t6_valid", 32'(kif.key_valid_out), 32'(1));
    check("t6_code", 32'(kif.key_code_out), 32'(4));
    cycles(SP);
    pressed = '0;
    cycles(4 * SP);

    // Randomised presses, bounces, multi-key and resets
    for (int it = 0; it < 80; it++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 6) mask = 12'(1) << $urandom_range(0, 11);
      else if (kind == 7) mask = '0;
      else if (kind == 8) mask = (12'(1) << $urandom_range(0, 11)) | (12'(1) << $urandom_range(0, 11));
      else mask = 12'($urandom);
      scans = int'($urandom_range(1, 7));
      if ($urandom_range(0, 3) == 0) cycles(int'($urandom_range(1, SP - 1)));
      pressed = mask;
      cycles(scans * SP);
      if ($urandom_range(0, 19) == 0) do_reset();
    end
    pressed = '0;
    cycles(5 * SP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
